// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU operand width and one-hot helper
package fpu_pkg;
  localparam int FP_W = 32;
  localparam int OH_W = 32;
  function automatic logic [OH_W-1:0] onehot(input int idx, input int n);
    return (idx >= 0 && idx < n) ? OH_W'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of small owner tags for in-flight pipelined operations
// clk, reset         : clock, synchronous active-high reset (empties the FIFO)
// push, push_tag     : enqueue a tag (caller pops in the same cycle when full)
// pop, head_tag      : dequeue the oldest tag; head_tag shows it combinationally
// count, full, empty : occupancy
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TW = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  output logic [TW-1:0] head_tag,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head_tag = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
      if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= push_tag;
endmodule

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one in-order pipelined fadd among NREQ requesters
// req_valid/req_op1/req_op2/req_ready : per-requester operand handshake (one-hot grant)
// fu_op1/fu_op2/fu_issue              : operands to the fadd unit
// fu_done/fu_result                   : in-order results from the fadd unit
// res_valid/res_data                  : one-hot result routing back to the issuer
// err_orphan                          : sticky flag for a result with nothing in flight
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DEPTH = 8,
  parameter int W = FP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_op1,
  input  logic [NREQ*W-1:0] req_op2,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      fu_op1,
  output logic [W-1:0]      fu_op2,
  output logic              fu_issue,
  input  logic              fu_done,
  input  logic [W-1:0]      fu_result,
  output logic [NREQ-1:0]   res_valid,
  output logic [W-1:0]      res_data,
  output logic              err_orphan
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW:0] NR = NREQ[IW:0];
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
  logic [IW-1:0] rr_ptr, off, win, head_tag;
  logic [IW:0] sum;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic [CW-1:0] count;
  logic full, empty, found, grant, pop;
  // rot[k] is requester (rr_ptr+k) mod NREQ, so the lowest set bit is the round-robin winner
  assign dbl = {req_valid, req_valid} >> rr_ptr;
  assign rot = dbl[NREQ-1:0];
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) begin found = 1'b1; off = IW'(k); end
  end
  assign sum = {1'b0, rr_ptr} + {1'b0, off};
  assign win = sum >= NR ? IW'(sum - NR) : sum[IW-1:0];
  // a full FIFO that pops this cycle still has room for the new tag
  assign grant = found && (!full || fu_done) && !reset;
  assign req_ready = grant ? NREQ'(onehot(int'(win), NREQ)) : '0;
  assign fu_issue = grant;
  assign fu_op1 = grant ? req_op1[win*W +: W] : '0;
  assign fu_op2 = grant ? req_op2[win*W +: W] : '0;
  assign pop = fu_done && !empty && !reset;
  assign res_valid = pop ? NREQ'(onehot(int'(head_tag), NREQ)) : '0;
  assign res_data = reset ? '0 : fu_result;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant) rr_ptr <= win == LAST ? '0 : win + IW'(1);
      if (fu_done && count == '0) err_orphan <= 1'b1;
    end
  end
  tag_fifo #(.DEPTH(DEPTH), .TW(IW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(grant),
    .push_tag(win),
    .pop(pop),
    .head_tag(head_tag),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule
